// File: rtl/parallel_out_fifo_if.sv
// rtl/parallel_out_fifo_if.sv - Ibex-style data bus interface shared by bus peripherals
interface bus_if;
    logic        req;
    logic        gnt;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;

    modport master (output req, we, addr, wdata, input gnt, rdata, rvalid, err);
    modport slave  (input req, we, addr, wdata, output gnt, rdata, rvalid, err);
endinterface

// File: rtl/parallel_out_fifo.sv
// rtl/parallel_out_fifo.sv - memory-mapped FIFO-backed parallel output port with gap timer
module parallel_out_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_RST    = 15
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    bus_if.slave              bus,
    output logic              parout_valid,
    output logic [DATA_W-1:0] parout,
    input  logic              parout_ready
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PRESENT} state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_cnt, w_cnt_nxt;
    logic               r_en, r_ovf, r_rvalid;
    logic [7:0]         r_gap;
    logic [31:0]        r_rdata, w_rdata_nxt;
    logic [PTR_W-1:0]   r_wptr, r_rptr;
    logic [LVL_W-1:0]   r_level;
    logic [DATA_W-1:0]  r_out, r_readback;
    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];

    logic       w_wr, w_rd, w_sel_ctrl, w_sel_data, w_sel_status, w_sel_gap;
    logic       w_flush, w_push_req, w_push_ok, w_ovf_set, w_pop, w_accept;
    logic       w_full, w_empty, w_busy;
    logic [3:0] w_off;
    logic [7:0] w_level8;
    logic       w_unused_bits;

    assign w_off        = bus.addr[3:0];
    assign w_wr         = bus.req & bus.we;
    assign w_rd         = bus.req & ~bus.we;
    assign w_sel_ctrl   = (w_off == 4'h0);
    assign w_sel_data   = (w_off == 4'h4);
    assign w_sel_status = (w_off == 4'h8);
    assign w_sel_gap    = (w_off == 4'hC);

    assign w_full   = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty  = (r_level == '0);
    assign w_busy   = (r_state != S_IDLE);
    assign w_level8 = 8'(r_level);

    // FLUSH wins over everything in its cycle: no pop, no push, no overflow.
    assign w_flush    = w_wr & w_sel_ctrl & bus.wdata[1];
    assign w_push_req = w_wr & w_sel_data;
    assign w_pop      = (r_state == S_IDLE) & r_en & ~w_empty & ~w_flush;
    assign w_push_ok  = w_push_req & ~w_flush & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & ~w_flush & w_full & ~w_pop;
    assign w_accept   = (r_state == S_PRESENT) & parout_ready & ~w_flush;

    assign bus.gnt    = bus.req;
    assign bus.err    = 1'b0;
    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;

    assign parout_valid = (r_state == S_PRESENT);
    assign parout       = parout_valid ? r_out : '0;

    assign w_unused_bits = &{1'b0, bus.addr[31:4], bus.wdata};

    // Drain FSM next state and gap counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = r_gap;
                end
            end
            S_WAIT: begin
                if (r_cnt == 8'd0) w_state_nxt = S_PRESENT;
                else               w_cnt_nxt   = r_cnt - 8'd1;
            end
            S_PRESENT: begin
                if (parout_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_flush) w_state_nxt = S_IDLE;
    end

    // Register read multiplexer; zero for writes, idle cycles and unmapped offsets.
    always_comb begin
        w_rdata_nxt = 32'h0;
        if (w_rd) begin
            case (w_off)
                4'h0:    w_rdata_nxt = {31'h0, r_en};
                4'h4:    w_rdata_nxt = 32'(r_readback);
                4'h8:    w_rdata_nxt = {16'h0, w_level8, 4'h0, r_ovf, w_empty, w_full, w_busy};
                4'hC:    w_rdata_nxt = {24'h0, r_gap};
                default: w_rdata_nxt = 32'h0;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the level gates every read.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) r_mem[r_wptr] <= bus.wdata[DATA_W-1:0];
    end

    // FSM state, output word, registers, FIFO pointers and bus response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_en       <= 1'b0;
            r_ovf      <= 1'b0;
            r_gap      <= 8'(GAP_RST);
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_out      <= '0;
            r_readback <= '0;
            r_rvalid   <= 1'b0;
            r_rdata    <= 32'h0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rvalid <= bus.req;
            r_rdata  <= w_rdata_nxt;

            if (w_wr && w_sel_ctrl) r_en  <= bus.wdata[0];
            if (w_wr && w_sel_gap)  r_gap <= bus.wdata[7:0];

            if (w_ovf_set)                                  r_ovf <= 1'b1;
            else if (w_wr && w_sel_status && bus.wdata[3]) r_ovf <= 1'b0;

            if (w_pop)    r_out      <= r_mem[r_rptr];
            if (w_accept) r_readback <= r_out;

            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                if (w_push_ok)
                    r_wptr <= (r_wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
                if (w_pop)
                    r_rptr <= (r_rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
                if (w_push_ok && !w_pop)      r_level <= r_level + LVL_W'(1);
                else if (w_pop && !w_push_ok) r_level <= r_level - LVL_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_parallel_out_fifo.sv
// tb/tb_parallel_out_fifo.sv - self-checking bench for parallel_out_fifo
module tb_parallel_out_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          parout_valid;
    logic          parout_ready;
    logic [DW-1:0] parout;

    int chk_cnt = 0;
    int err_cnt = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] m_fifo[$];
    bit            m_ovf;
    bit            mon_en = 1'b0;

    always #5 clk = ~clk;

    bus_if bus ();

    parallel_out_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .GAP_RST(15)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .bus          (bus),
        .parout_valid (parout_valid),
        .parout       (parout),
        .parout_ready (parout_ready)
    );

    // A word is consumed at the rising edge following a negedge with valid & ready.
    always @(negedge clk) begin
        if (mon_en && parout_valid && parout_ready) got_q.push_back(parout);
    end

    function automatic logic [31:0] stat(bit busy, bit full, bit empty, bit ovf, int lvl);
        return {16'h0, 8'(lvl), 4'h0, ovf, empty, full, busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        tick();
        bus.req = 1'b0; bus.we = 1'b0; bus.wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] rd, output logic rv);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = a;
        tick();
        rd = bus.rdata;
        rv = bus.rvalid;
        bus.req = 1'b0;
    endtask

    task automatic do_reset();
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
        parout_ready = 1'b0;
        mon_en = 1'b0;
        got_q.delete(); exp_q.delete(); m_fifo.delete(); m_ovf = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic rv;
        rst_n = 1'b0;
        #3;
        if (parout_valid !== 1'b0 || parout !== '0 || bus.rvalid !== 1'b0 || bus.rdata !== 32'h0) begin
            $display("FAIL reset_outputs: valid=%b parout=%h rvalid=%b rdata=%h, want all 0",
                     parout_valid, parout, bus.rvalid, bus.rdata);
            err_cnt++;
        end
        chk_cnt++;
        do_reset();
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h8;
        #1;
        if (bus.gnt !== 1'b1 || bus.rvalid !== 1'b0 || bus.err !== 1'b0) begin
            $display("FAIL gnt_same_cycle: gnt=%b rvalid=%b err=%b, want 1 0 0", bus.gnt, bus.rvalid, bus.err);
            err_cnt++;
        end
        chk_cnt++;
        @(posedge clk); #1;
        rd = bus.rdata; rv = bus.rvalid; bus.req = 1'b0;
        if (rv !== 1'b1 || rd !== 32'h4) begin
            $display("FAIL reset_status: rvalid=%b rdata=%h, want 1 00000004", rv, rd);
            err_cnt++;
        end
        chk_cnt++;
        tick();
        if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h0) begin
            $display("FAIL idle_bus: rvalid=%b rdata=%h, want 0 0", bus.rvalid, bus.rdata);
            err_cnt++;
        end
        chk_cnt++;
        bus_read(32'hC, rd, rv);
        if (rd !== 32'd15) begin $display("FAIL reset_gap: got %0d want 15", rd); err_cnt++; end
        chk_cnt++;
        bus_read(32'h0, rd, rv);
        if (rd !== 32'h0) begin $display("FAIL reset_ctrl: got %h want 0", rd); err_cnt++; end
        chk_cnt++;
        bus_read(32'h4, rd, rv);
        if (rd !== 32'h0) begin $display("FAIL reset_readback: got %h want 0", rd); err_cnt++; end
        chk_cnt++;
        bus_read(32'h2, rd, rv);
        if (rd !== 32'h0) begin $display("FAIL unmapped_read: got %h want 0", rd); err_cnt++; end
        chk_cnt++;
    endtask

    task automatic test_latency();
        logic [31:0] rd; logic rv;
        logic [DW-1:0] d;
        int g;
        do_reset();
        parout_ready = 1'b1;
        bus_write(32'h0, 32'h1);
        for (int it = 0; it < 4; it++) begin
            g = (it == 0) ? 3 : $urandom_range(0, 6);
            d = DW'($urandom);
            bus_write(32'hC, 32'(g));
            bus_write(32'h4, 32'(d));
            for (int k = 0; k <= g + 5; k++) begin
                if (k > 0) tick();
                if (parout_valid !== (k == g + 2)) begin
                    $display("FAIL latency_valid: gap=%0d cycle=%0d valid=%b want %b", g, k, parout_valid, (k == g + 2));
                    err_cnt++;
                end
                chk_cnt++;
                if (parout !== ((k == g + 2) ? d : DW'(0))) begin
                    $display("FAIL latency_word: gap=%0d cycle=%0d parout=%h want %h", g, k, parout, (k == g + 2) ? d : DW'(0));
                    err_cnt++;
                end
                chk_cnt++;
            end
            bus_read(32'h4, rd, rv);
            if (rd !== 32'(d)) begin $display("FAIL latency_readback: got %h want %h", rd, d); err_cnt++; end
            chk_cnt++;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd; logic rv;
        logic [DW-1:0] d;
        do_reset();
        bus_write(32'hC, 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = DW'($urandom);
            bus_write(32'h4, 32'(d));
            if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
            else                       m_ovf = 1'b1;
        end
        bus_read(32'h8, rd, rv);
        if (rd !== stat(0, m_fifo.size() == DEPTH, 0, m_ovf, m_fifo.size())) begin
            $display("FAIL ovf_status: got %h want %h", rd, stat(0, m_fifo.size() == DEPTH, 0, m_ovf, m_fifo.size()));
            err_cnt++;
        end
        chk_cnt++;
        exp_q = m_fifo;
        parout_ready = 1'b1;
        mon_en = 1'b1;
        bus_write(32'h0, 32'h1);
        wait_words(exp_q.size(), 200);
        repeat (20) tick();
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL ovf_count: got %0d words want %0d", got_q.size(), exp_q.size());
            err_cnt++;
        end
        chk_cnt++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL ovf_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
                err_cnt++;
            end
            chk_cnt++;
        end
        bus_read(32'h8, rd, rv);
        if (rd !== stat(0, 0, 1, m_ovf, 0)) begin
            $display("FAIL ovf_sticky: got %h want %h", rd, stat(0, 0, 1, m_ovf, 0));
            err_cnt++;
        end
        chk_cnt++;
        bus_write(32'h8, 32'h8);
        m_ovf = 1'b0;
        bus_read(32'h8, rd, rv);
        if (rd !== stat(0, 0, 1, m_ovf, 0)) begin
            $display("FAIL ovf_clear: got %h want %h", rd, stat(0, 0, 1, m_ovf, 0));
            err_cnt++;
        end
        chk_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic rv;
        logic [DW-1:0] d0, d1;
        int n;
        do_reset();
        d0 = DW'($urandom); d1 = DW'($urandom);
        bus_write(32'hC, 32'h0);
        bus_write(32'h0, 32'h1);
        bus_write(32'h4, 32'(d0));
        bus_write(32'h4, 32'(d1));
        n = 0;
        while (!parout_valid && n < 20) begin tick(); n++; end
        bus_read(32'h8, rd, rv);
        if (rd !== stat(1, 0, 0, 0, 1)) begin $display("FAIL hold_status_a: got %h want %h", rd, stat(1, 0, 0, 0, 1)); err_cnt++; end
        chk_cnt++;
        for (int k = 0; k < 10; k++) begin
            if (parout_valid !== 1'b1 || parout !== d0) begin
                $display("FAIL hold_word: cycle=%0d valid=%b parout=%h want 1 %h", k, parout_valid, parout, d0);
                err_cnt++;
            end
            chk_cnt++;
            tick();
        end
        bus_read(32'h8, rd, rv);
        if (rd !== stat(1, 0, 0, 0, 1)) begin $display("FAIL hold_status_b: got %h want %h", rd, stat(1, 0, 0, 0, 1)); err_cnt++; end
        chk_cnt++;
        parout_ready = 1'b1;
        tick();
        parout_ready = 1'b0;
        if (parout_valid !== 1'b0) begin $display("FAIL single_accept: valid=%b want 0", parout_valid); err_cnt++; end
        chk_cnt++;
        bus_read(32'h4, rd, rv);
        if (rd !== 32'(d0)) begin $display("FAIL hold_readback: got %h want %h", rd, d0); err_cnt++; end
        chk_cnt++;
        mon_en = 1'b1;
        parout_ready = 1'b1;
        wait_words(1, 20);
        if (got_q.size() != 1 || got_q[0] !== d1) begin
            $display("FAIL hold_next: got %0d words first=%h want 1 %h", got_q.size(), got_q.size() ? got_q[0] : DW'(0), d1);
            err_cnt++;
        end
        chk_cnt++;
    endtask

    task automatic test_full_push_pop();
        logic [31:0] rd; logic rv;
        logic [DW-1:0] d;
        do_reset();
        bus_write(32'hC, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            d = DW'($urandom);
            bus_write(32'h4, 32'(d));
            m_fifo.push_back(d);
        end
        bus_read(32'h8, rd, rv);
        if (rd !== stat(0, 1, 0, 0, DEPTH)) begin $display("FAIL full_status: got %h want %h", rd, stat(0, 1, 0, 0, DEPTH)); err_cnt++; end
        chk_cnt++;
        // Enable, then push in the very next cycle, which is the pop cycle.
        bus_write(32'h0, 32'h1);
        d = DW'($urandom);
        bus_write(32'h4, 32'(d));
        m_fifo.push_back(d);
        bus_read(32'h8, rd, rv);
        if (rd !== stat(1, 1, 0, 0, DEPTH)) begin $display("FAIL pushpop_status: got %h want %h", rd, stat(1, 1, 0, 0, DEPTH)); err_cnt++; end
        chk_cnt++;
        exp_q = m_fifo;
        mon_en = 1'b1;
        parout_ready = 1'b1;
        wait_words(exp_q.size(), 200);
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL pushpop_count: got %0d want %0d", got_q.size(), exp_q.size());
            err_cnt++;
        end
        chk_cnt++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL pushpop_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
                err_cnt++;
            end
            chk_cnt++;
        end
        bus_read(32'h8, rd, rv);
        if (rd !== stat(0, 0, 1, 0, 0)) begin $display("FAIL pushpop_drained: got %h want %h", rd, stat(0, 0, 1, 0, 0)); err_cnt++; end
        chk_cnt++;
    endtask

    task automatic test_random_stream();
        logic [31:0] rd; logic rv;
        logic [DW-1:0] d;
        bit done;
        do_reset();
        bus_write(32'hC, 32'($urandom_range(0, 2)));
        bus_write(32'h0, 32'h1);
        mon_en = 1'b1;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    d = DW'($urandom);
                    exp_q.push_back(d);
                    bus_write(32'h4, 32'(d));
                    repeat ($urandom_range(8, 12)) tick();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    parout_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        parout_ready = 1'b1;
        wait_words(exp_q.size(), 300);
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL stream_count: got %0d want %0d", got_q.size(), exp_q.size());
            err_cnt++;
        end
        chk_cnt++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL stream_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
                err_cnt++;
            end
            chk_cnt++;
        end
        bus_read(32'h8, rd, rv);
        if (rd !== stat(0, 0, 1, 0, 0)) begin $display("FAIL stream_status: got %h want %h", rd, stat(0, 0, 1, 0, 0)); err_cnt++; end
        chk_cnt++;
    endtask

    task automatic test_flush_reset();
        logic [31:0] rd; logic rv;
        int n;
        do_reset();
        bus_write(32'hC, 32'h0);
        bus_write(32'h0, 32'h1);
        for (int i = 0; i < 4; i++) bus_write(32'h4, 32'($urandom));
        n = 0;
        while (!parout_valid && n < 20) begin tick(); n++; end
        bus_read(32'h8, rd, rv);
        if (rd !== stat(1, 0, 0, 0, 3)) begin $display("FAIL preflush_status: got %h want %h", rd, stat(1, 0, 0, 0, 3)); err_cnt++; end
        chk_cnt++;
        bus_write(32'h0, 32'h3);
        if (parout_valid !== 1'b0 || parout !== '0) begin
            $display("FAIL flush_output: valid=%b parout=%h want 0 0", parout_valid, parout);
            err_cnt++;
        end
        chk_cnt++;
        bus_read(32'h8, rd, rv);
        if (rd !== stat(0, 0, 1, 0, 0)) begin $display("FAIL flush_status: got %h want %h", rd, stat(0, 0, 1, 0, 0)); err_cnt++; end
        chk_cnt++;
        bus_read(32'h0, rd, rv);
        if (rd !== 32'h1) begin $display("FAIL flush_ctrl: got %h want 1", rd); err_cnt++; end
        chk_cnt++;
        // Reset in the middle of a long gap while a read response is pending.
        bus_write(32'hC, 32'd10);
        bus_write(32'h4, 32'($urandom));
        repeat (3) tick();
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h0;
        tick();
        if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h1) begin
            $display("FAIL prereset_read: rvalid=%b rdata=%h want 1 1", bus.rvalid, bus.rdata);
            err_cnt++;
        end
        chk_cnt++;
        #2 rst_n = 1'b0;
        #1;
        if (parout_valid !== 1'b0 || parout !== '0 || bus.rvalid !== 1'b0 || bus.rdata !== 32'h0) begin
            $display("FAIL async_reset: valid=%b parout=%h rvalid=%b rdata=%h want all 0",
                     parout_valid, parout, bus.rvalid, bus.rdata);
            err_cnt++;
        end
        chk_cnt++;
        bus.req = 1'b0;
        tick();
        rst_n = 1'b1;
        bus_read(32'h8, rd, rv);
        if (rd !== stat(0, 0, 1, 0, 0)) begin $display("FAIL postreset_status: got %h want %h", rd, stat(0, 0, 1, 0, 0)); err_cnt++; end
        chk_cnt++;
        bus_read(32'hC, rd, rv);
        if (rd !== 32'd15) begin $display("FAIL postreset_gap: got %0d want 15", rd); err_cnt++; end
        chk_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        parout_ready = 1'b0;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
        tick();
        test_reset();
        test_latency();
        test_overflow();
        test_backpressure();
        test_full_push_pop();
        test_random_stream();
        test_flush_reset();
        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/parallel_out_fifo.md
Name: parallel_out_fifo

Overview:
- Memory-mapped parallel output port and the parametrised successor of the single-byte parallel output peripheral.
- Software writes words into a FIFO over the bus slave interface.
- A drain FSM presents each word on `parout` after a programmable inter-word gap and holds it under a valid/ready handshake.
- Sits on the Ibex data bus next to the other bus_if peripherals.

Parameters:
- DATA_W, 8, width of `parout` and of each FIFO entry; 1..32.
- FIFO_DEPTH, 8, number of FIFO entries; 2..255, need not be a power of two.
- GAP_RST, 15, reset value of the GAP register (inter-word gap in cycles).

Ports:
- clk_i  input  1  clock; all state on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- bus  bus_if.slave  -  req, gnt, we, addr, wdata, rdata, rvalid, err.
- parout_valid  output  1  `parout` holds a valid word.
- parout  output  DATA_W  output word; all zeros whenever `parout_valid`=0.
- parout_ready  input  1  consumer accepts the word on a cycle where valid & ready.

Behaviour:
Bus:
- gnt = req (combinational); err = 0.
- rvalid is registered req (one-cycle latency).
- rdata is registered. It is 0 for writes, for unmapped offsets, and in cycles with no request.
- Decode uses addr[3:0].

Register map:
- 0x0 CTRL, RW. bit0 EN (reset 0). bit1 FLUSH is write-1 and self-clearing; it reads as 0.
- 0x4 DATA. A write pushes wdata[DATA_W-1:0]. A read returns the last word accepted by the consumer (reset 0), zero-extended.
- 0x8 STATUS. bit0 BUSY (FSM not IDLE), bit1 FULL, bit2 EMPTY, bit3 OVF (sticky; writing 1 to bit3 clears it), bits[15:8] LEVEL. All other bits read 0.
- 0xC GAP, RW. bits[7:0] hold the gap count; reset GAP_RST.

FIFO:
- Circular buffer with read/write pointers wrapping at FIFO_DEPTH-1 to 0, plus a level counter.
- A push is accepted if the FIFO is not full, or if a pop happens in the same cycle. In that case the level is unchanged and no overflow occurs.
- A push that is not accepted is dropped and sets OVF. FIFO contents are unchanged.
- FLUSH: pointers and level go to 0 on the next edge. A push in the same cycle as FLUSH is dropped without setting OVF.

Drain FSM:
- IDLE:
  - EN=1 and not empty: pop the head into the output register, load cnt=GAP, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - cnt==0: go to PRESENT.
  - Otherwise cnt decrements by 1.
- PRESENT: `parout_valid`=1 and `parout`=output register.
  - On valid & ready, the word is copied to the DATA read-back and the FSM goes to IDLE.
  - The next word cannot be popped before the following cycle.
- Latency: a push at edge e into an empty FIFO with EN=1 and an idle FSM gives `parout_valid` high from edge e+2+GAP.
  - Minimum spacing between accepted words (ready held 1) is GAP+3 cycles.
- Clearing EN does not abort WAIT or PRESENT; it only blocks the next pop.
- FLUSH forces the FSM to IDLE at the next edge, including from WAIT or PRESENT. The in-flight word is discarded and `parout_valid` drops.
- A GAP write during WAIT does not affect the current count; it applies from the next pop.
- Reset, asynchronous and at any time, returns:
  - FSM=IDLE, FIFO empty, OVF=0, EN=0.
  - GAP=GAP_RST, read-back=0.
  - `parout_valid`=0, `parout`=0, rvalid=0, rdata=0.

Test Plan:
- Reset, then read 0x8 -> rdata=0x00000004 (EMPTY=1), rvalid one cycle after req. Read 0xC -> 15.
- EN=1, GAP=3, write DATA=0xA5 at edge e, parout_ready=1 -> `parout_valid` high only in cycle from e+5, `parout`=0xA5. DATA read-back = 0xA5 afterwards.
- EN=0, write 9 words 0x01..0x09 (depth 8) -> STATUS = FULL, OVF set, LEVEL=8. Set EN=1 with ready=1 -> outputs 0x01..0x08 in order, 0x09 never appears. Write 0x8 with bit3 set -> OVF=0.
- EN=1, GAP=0, ready low for 10 cycles -> `parout` holds the word with valid=1 throughout and no pop occurs (LEVEL constant). Raise ready -> word accepted in exactly one cycle.
- With FIFO full, push in the same cycle as a pop -> accepted, LEVEL stays at FIFO_DEPTH, OVF stays 0.
- FLUSH during PRESENT with 3 words queued -> next cycle valid=0, LEVEL=0, BUSY=0. Assert rst_ni low mid-WAIT -> all outputs 0 immediately.
